uart_frame_rx: RTL and testbench

- Receive-side front end for the encryptor datapath. Turns the serial RX line into the 80-bit code word consumed by the encryptor core.
- Deserialises 8N1 UART bytes and packs 10 consecutive bytes into one 80-bit frame.
- Presents the frame on odata with a one-cycle datavalid strobe. The top level latches odata into code_in on that strobe.
- Inter-byte timeout resynchronises framing after line noise or a truncated transmission.

---
 rtl/enc_pkg.sv | 17 +
 rtl/uart_rx_byte.sv | 157 +++++++++++++++
 rtl/uart_frame_rx.sv | 108 ++++++++++
 tb/tb_uart_frame_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared encryptor-datapath definitions: UART bit-FSM states, frame width and
// default serial timing reused by both RX and TX sides.
package enc_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } uart_state_e;

   localparam int FRAME_W    = 80;
   localparam int CLK_HZ_DEF = 100_000_000;
   localparam int BAUD_DEF   = 9600;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: rx synchroniser, baud counter and bit FSM.
// Build option UART_PARITY_EN adds an even-parity bit between DATA and STOP.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for a falling edge on rx_s
// S_START | half a bit-time into the start bit, confirm it is still low
// S_DATA  | sample 8 data bits, LSB first, one per DIV clocks
// S_PAR   | sample the parity bit (UART_PARITY_EN builds only)
// S_STOP  | sample the stop bit, report byte_ok or byte_err
module uart_rx_byte
   import enc_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEF,
   parameter int BAUD   = BAUD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_byte,
   output logic       byte_ok,
   output logic       byte_err,
   output logic       rx_idle,
   output logic       rx_fall
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

   generate
      if (DIV < 4) begin : g_div_check
         $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
      end
   endgenerate

   logic rx_meta_q, rx_s_q, rx_prev_q;

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             par_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_s_q;
   assign rx_idle = (state_q == S_IDLE);
   assign rx_byte = sh_q;

`ifdef UART_PARITY_EN
   logic par_err_q, par_err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_err_q <= 1'b0;
      else        par_err_q <= par_err_d;
   end

   assign par_err = par_err_q;
`else
   assign par_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      byte_ok  = 1'b0;
      byte_err = 1'b0;
`ifdef UART_PARITY_EN
      par_err_d = par_err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (rx_fall) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               sh_d  = {rx_s_q, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_d = S_PAR;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_PARITY_EN
         S_PAR: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               // Even parity: the parity bit equals the XOR of the data bits.
               par_err_d = rx_s_q ^ (^sh_q);
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rx_s_q && !par_err) byte_ok  = 1'b1;
               else                    byte_err = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_frame_rx.sv
// Packs received UART bytes into FRAME_BYTES-byte frames (first byte in the MSBs),
// with an inter-byte idle timeout that discards partial frames.
module uart_frame_rx
   import enc_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int FRAME_BYTES  = FRAME_W / 8,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           rx,
   output logic [8*FRAME_BYTES-1:0]       odata,
   output logic                           datavalid,
   output logic                           frame_err,
   output logic [$clog2(FRAME_BYTES)-1:0] byte_cnt
);

   localparam int W       = 8 * FRAME_BYTES;
   localparam int BC_W    = $clog2(FRAME_BYTES);
   localparam int TO_CLKS = TIMEOUT_BITS * (CLK_HZ / BAUD);
   localparam int TO_W    = $clog2(TO_CLKS + 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BYTES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CLKS - 1);

   logic [7:0] rx_byte;
   logic       byte_ok, byte_err, rx_idle, rx_fall;

   uart_rx_byte #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_byte (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx       (rx),
      .rx_byte  (rx_byte),
      .byte_ok  (byte_ok),
      .byte_err (byte_err),
      .rx_idle  (rx_idle),
      .rx_fall  (rx_fall)
   );

   // Only the previous FRAME_BYTES-1 bytes need holding; the last one arrives live.
   logic [W-9:0]  acc_q, acc_d;
   logic [W-1:0]  odata_q, odata_d;
   logic          datavalid_q, datavalid_d;
   logic          frame_err_q, frame_err_d;
   logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q       <= '0;
         odata_q     <= '0;
         datavalid_q <= 1'b0;
         frame_err_q <= 1'b0;
         byte_cnt_q  <= '0;
         idle_cnt_q  <= '0;
      end else begin
         acc_q       <= acc_d;
         odata_q     <= odata_d;
         datavalid_q <= datavalid_d;
         frame_err_q <= frame_err_d;
         byte_cnt_q  <= byte_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
      end
   end

   always_comb begin
      acc_d       = acc_q;
      odata_d     = odata_q;
      datavalid_d = 1'b0;
      frame_err_d = 1'b0;
      byte_cnt_d  = byte_cnt_q;
      idle_cnt_d  = idle_cnt_q;

      if (byte_err) begin
         frame_err_d = 1'b1;
         byte_cnt_d  = '0;
      end else if (byte_ok) begin
         acc_d = {acc_q[W-17:0], rx_byte};
         if (byte_cnt_q == BC_LAST) begin
            odata_d     = {acc_q, rx_byte};
            datavalid_d = 1'b1;
            byte_cnt_d  = '0;
         end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
         end
      end

      // A start edge always wins over an expiring timeout.
      if (!rx_idle || byte_cnt_q == '0 || rx_fall) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q == TO_LAST) begin
         idle_cnt_d = '0;
         byte_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   assign odata     = odata_q;
   assign datavalid = datavalid_q;
   assign frame_err = frame_err_q;
   assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx at DIV=10: expected frames are queued by the
// stimulus and popped by a monitor whenever datavalid is seen.
module tb_uart_frame_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic [79:0] odata;
   logic        datavalid;
   logic        frame_err;
   logic [3:0]  byte_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int dv_cnt = 0;
   int ferr_cnt = 0;
   logic [79:0] exp_q[$];
   logic [79:0] last_odata = '0;
   logic        prev_dv = 1'b0;
   logic        prev_fe = 1'b0;

   logic [7:0] hello [10] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
                             8'h20, 8'h57, 8'h4F, 8'h52, 8'h4C};

   uart_frame_rx #(
      .CLK_HZ       (1_000_000),
      .BAUD         (100_000),
      .FRAME_BYTES  (10),
      .TIMEOUT_BITS (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .odata     (odata),
      .datavalid (datavalid),
      .frame_err (frame_err),
      .byte_cnt  (byte_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: scoreboard pop on datavalid, pulse-width and odata-hold checks.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_odata = odata;
         prev_dv = 1'b0;
         prev_fe = 1'b0;
      end else begin
         if (datavalid) begin
            dv_cnt++;
            chk("dv_width", {79'd0, prev_dv}, 80'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_frame: got %h expected none", odata);
            end else begin
               chk("frame", odata, exp_q.pop_front());
            end
         end else if (odata !== last_odata) begin
            n_cmp++;
            n_err++;
            $display("FAIL odata_hold: got %h expected %h", odata, last_odata);
         end
         if (frame_err) begin
            ferr_cnt++;
            chk("ferr_width", {79'd0, prev_fe}, 80'd0);
         end
         last_odata = odata;
         prev_dv = datavalid;
         prev_fe = frame_err;
      end
   end

   task automatic drive_bit(input logic v);
      @(posedge clk);
      #1 rx = v;
      repeat (9) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
      drive_bit((^b) ^ par_flip);
`endif
      drive_bit(stop_bit);
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      logic [79:0] exp_v;

      // Reset values
      repeat (3) @(posedge clk);
      at_neg();
      chk("rst_odata", odata, 80'd0);
      chk("rst_dv", {79'd0, datavalid}, 80'd0);
      chk("rst_ferr", {79'd0, frame_err}, 80'd0);
      chk("rst_bcnt", {76'd0, byte_cnt}, 80'd0);
      rst_n = 1'b1;
      idle(10);

      // Clean frame "HELLO WORL"
      exp_q.push_back(80'h48454C4C4F20574F524C);
      for (int i = 0; i < 10; i++) begin
         send_byte(hello[i], 1'b1, 1'b0);
         if (i == 2) begin
            at_neg();
            chk("bcnt_3", {76'd0, byte_cnt}, 80'd3);
         end
      end
      idle(5);
      at_neg();
      chk("hello_dv", dv_cnt, 1);
      chk("hello_ferr", ferr_cnt, 0);
      chk("hello_bcnt", {76'd0, byte_cnt}, 80'd0);

      // Stop-bit error on the third byte
      send_byte(8'h10, 1'b1, 1'b0);
      send_byte(8'h20, 1'b1, 1'b0);
      send_byte(8'h30, 1'b0, 1'b0);
      idle(20);
      at_neg();
      chk("stop_ferr", ferr_cnt, 1);
      chk("stop_bcnt", {76'd0, byte_cnt}, 80'd0);
      chk("stop_hold", odata, 80'h48454C4C4F20574F524C);
      exp_q.push_back(80'hA1A2A3A4A5A6A7A8A9AA);
      for (int i = 0; i < 10; i++) send_byte(8'hA1 + 8'(i), 1'b1, 1'b0);
      idle(5);
      at_neg();
      chk("stop_next_dv", dv_cnt, 2);

      // Short glitch while idle
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (3) @(posedge clk);
      #1 rx = 1'b1;
      repeat (30) @(posedge clk);
      at_neg();
      chk("glitch_bcnt", {76'd0, byte_cnt}, 80'd0);
      chk("glitch_ferr", ferr_cnt, 1);
      chk("glitch_dv", dv_cnt, 2);

      // Inter-byte timeout
      for (int i = 0; i < 4; i++) send_byte(8'hC1 + 8'(i), 1'b1, 1'b0);
      at_neg();
      chk("to_bcnt4", {76'd0, byte_cnt}, 80'd4);
      idle(100);
      at_neg();
      chk("to_pre", {76'd0, byte_cnt}, 80'd4);
      idle(110);
      at_neg();
      chk("to_post", {76'd0, byte_cnt}, 80'd0);
      chk("to_ferr", ferr_cnt, 1);
      exp_q.push_back(80'h0102030405060708090A);
      for (int i = 0; i < 10; i++) send_byte(8'h01 + 8'(i), 1'b1, 1'b0);
      idle(5);
      at_neg();
      chk("to_dv", dv_cnt, 3);

      // Reset in the middle of the 7th byte
      for (int i = 0; i < 6; i++) send_byte(8'h55, 1'b1, 1'b0);
      at_neg();
      chk("pre_rst_bcnt", {76'd0, byte_cnt}, 80'd6);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_odata", odata, 80'd0);
      chk("arst_bcnt", {76'd0, byte_cnt}, 80'd0);
      chk("arst_dv", {79'd0, datavalid}, 80'd0);
      chk("arst_ferr", {79'd0, frame_err}, 80'd0);
      rx = 1'b1;
      repeat (5) @(posedge clk);
      at_neg();
      rst_n = 1'b1;
      idle(20);
      exp_v = '1;
      exp_q.push_back(exp_v);
      for (int i = 0; i < 10; i++) send_byte(8'hFF, 1'b1, 1'b0);
      idle(5);
      at_neg();
      chk("ones_dv", dv_cnt, 4);

`ifdef UART_PARITY_EN
      send_byte(8'h41, 1'b1, 1'b1);
      idle(5);
      at_neg();
      chk("par_bad_ferr", ferr_cnt, 2);
      chk("par_bad_bcnt", {76'd0, byte_cnt}, 80'd0);
      send_byte(8'h41, 1'b1, 1'b0);
      idle(5);
      at_neg();
      chk("par_ok_bcnt", {76'd0, byte_cnt}, 80'd1);
      chk("par_ok_ferr", ferr_cnt, 2);
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
